// File: rtl/rv_regfile_mp.sv
// rv_regfile_mp: multi-port RV32I/RV32E integer register file.
// It sits between decode (read ports) and execute (write port).
// - Read latency is one cycle, with optional same-cycle write-to-read bypass.
// - A stall holds the read outputs, and a write to a held address refreshes that output.
// - After reset, a scrub FSM zeroes the array. busy_o is high while it runs.
// - illegal_o pulses for one cycle when an access uses an address >= NREGS.
// Ports:
//   clk_i, rst_i        clock and asynchronous active-high reset
//   raddr_i  [NRD*5]    read addresses, 5 bits per port
//   rdata_o  [NRD*XLEN] registered read data, XLEN bits per port
//   we_i, waddr_i, wdata_i   write port
//   wait_i              stall; holds read outputs
//   busy_o              scrub in progress
//   illegal_o           out-of-range access pulse
module rv_regfile_mp #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NRD*5-1:0]      raddr_i,
    output logic [NRD*XLEN-1:0]   rdata_o,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic                  wait_i,
    output logic                  busy_o,
    output logic                  illegal_o
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned RW = 5;

    typedef enum logic {SCRUB, RUN} state_t;

    logic [XLEN-1:0]     mem_q [NREGS];
    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                illegal_q, illegal_d;
    logic [NRD*XLEN-1:0] rdata_q, rdata_d;
    logic [NRD*RW-1:0]   raddr_q, raddr_d;
    logic                mem_we;
    logic [AW-1:0]       mem_wa;
    logic [XLEN-1:0]     mem_wd;
    logic                wr_legal;

    // True when a 5-bit address names an implemented register.
    function automatic logic in_range(input logic [RW-1:0] a);
        return {1'b0, a} < 6'(NREGS);
    endfunction

    // x0 is never written. Out-of-range writes are dropped.
    assign wr_legal = we_i && (waddr_i != '0) && in_range(waddr_i);

    // Compute the next state, the read data and the array write strobe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        illegal_d = 1'b0;
        rdata_d   = rdata_q;
        raddr_d   = raddr_q;
        mem_we    = 1'b0;
        mem_wa    = cnt_q;
        mem_wd    = '0;

        case (state_q)
            SCRUB: begin
                mem_we  = 1'b1;
                mem_wa  = cnt_q;
                mem_wd  = '0;
                cnt_d   = cnt_q + AW'(1);
                rdata_d = '0;
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                mem_we    = wr_legal;
                mem_wa    = AW'(waddr_i);
                mem_wd    = wdata_i;
                illegal_d = we_i && !in_range(waddr_i);
                for (int unsigned p = 0; p < NRD; p++) begin
                    if (!wait_i) begin
                        raddr_d[RW*p +: RW] = raddr_i[RW*p +: RW];
                        if (!in_range(raddr_i[RW*p +: RW])) begin
                            illegal_d = 1'b1;
                        end
                        if ((raddr_i[RW*p +: RW] == '0) || !in_range(raddr_i[RW*p +: RW])) begin
                            rdata_d[XLEN*p +: XLEN] = '0;
                        end else if (BYPASS && wr_legal && (waddr_i == raddr_i[RW*p +: RW])) begin
                            rdata_d[XLEN*p +: XLEN] = wdata_i;
                        end else begin
                            rdata_d[XLEN*p +: XLEN] = mem_q[AW'(raddr_i[RW*p +: RW])];
                        end
                    end else if (wr_legal && (waddr_i == raddr_q[RW*p +: RW])) begin
                        // A held output tracks writes to its captured address, so it never goes stale.
                        rdata_d[XLEN*p +: XLEN] = wdata_i;
                    end
                end
            end
            default: begin
                state_d = SCRUB;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= SCRUB;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
            raddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
            rdata_q   <= rdata_d;
            raddr_q   <= raddr_d;
        end
    end

    // The register array has no reset. Zeroing is done only by the scrub FSM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign rdata_o   = rdata_q;
    assign busy_o    = busy_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Directed bench for rv_regfile_mp.
// Three instances share the same stimulus:
//   dut    default configuration (32 registers, bypass enabled)
//   dut_nb bypass disabled
//   dut16  16-register (RV32E) configuration
module tb_rv_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wt;

    logic [63:0] rd, rd_nb, rd16;
    logic        busy, busy_nb, busy16;
    logic        ill, ill_nb, ill16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rd), .we_i(we),
        .waddr_i(waddr), .wdata_i(wdata), .wait_i(wt), .busy_o(busy), .illegal_o(ill));

    rv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b0)) dut_nb (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rd_nb), .we_i(we),
        .waddr_i(waddr), .wdata_i(wdata), .wait_i(wt), .busy_o(busy_nb), .illegal_o(ill_nb));

    rv_regfile_mp #(.XLEN(32), .NREGS(16), .NRD(2), .BYPASS(1'b1)) dut16 (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rd16), .we_i(we),
        .waddr_i(waddr), .wdata_i(wdata), .wait_i(wt), .busy_o(busy16), .illegal_o(ill16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release reset and count edges until busy drops on both configurations.
    task automatic scrub_count(output int e32, output int e16);
        e32 = 0;
        e16 = 0;
        rst = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (!busy && e32 == 0) e32 = n;
            if (!busy16 && e16 == 0) e16 = n;
            if (e32 != 0 && e16 != 0) break;
        end
    endtask

    initial begin
        int e32, e16;
        rst = 1'b1; raddr = '0; we = 1'b0; waddr = '0; wdata = '0; wt = 1'b0;
        step();
        step();
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_rdata", rd[31:0] | rd[63:32], 32'd0);
        check("reset_illegal", 32'(ill), 32'd0);

        // T1: scrub length, then every register reads zero.
        scrub_count(e32, e16);
        check("scrub_edges32", 32'(e32), 32'd32);
        check("scrub_edges16", 32'(e16), 32'd16);
        for (int i = 1; i < 32; i++) begin
            raddr = {5'(32 - i), 5'(i)};
            step();
            check($sformatf("t1_x%0d_p0", i), rd[31:0], 32'd0);
            check($sformatf("t1_x%0d_p1", 32 - i), rd[63:32], 32'd0);
        end

        // T2: write x5, then read x5 and x0.
        raddr = '0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        we = 1'b0; raddr = {5'd0, 5'd5};
        step();
        check("t2_rd0_x5", rd[31:0], 32'hDEADBEEF);
        check("t2_rd1_x0", rd[63:32], 32'd0);

        // T3: a same-cycle write and read of x7, with and without bypass.
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr = {5'd5, 5'd7};
        step();
        check("t3_bypass_rd0", rd[31:0], 32'h12345678);
        check("t3_nobypass_rd0", rd_nb[31:0], 32'd0);
        check("t3_bypass_rd1", rd[63:32], 32'hDEADBEEF);
        we = 1'b0;
        step();
        check("t3_nobypass_after", rd_nb[31:0], 32'h12345678);

        // T4: a stall holds the outputs, and a write to a held address refreshes it.
        we = 1'b1; waddr = 5'd3; wdata = 32'h11; raddr = '0;
        step();
        we = 1'b0; raddr = {5'd5, 5'd3};
        step();
        check("t4_capture_rd0", rd[31:0], 32'h11);
        check("t4_capture_rd1", rd[63:32], 32'hDEADBEEF);
        wt = 1'b1; raddr = {5'd7, 5'd9}; we = 1'b1; waddr = 5'd3; wdata = 32'h22;
        step();
        check("t4_stall1_rd0", rd[31:0], 32'h22);
        check("t4_stall1_rd1", rd[63:32], 32'hDEADBEEF);
        check("t4_stall1_nb_rd0", rd_nb[31:0], 32'h22);
        we = 1'b0; raddr = {5'd7, 5'd1};
        step();
        check("t4_stall2_rd0", rd[31:0], 32'h22);
        check("t4_stall2_rd1", rd[63:32], 32'hDEADBEEF);
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        step();
        check("t4_stall3_rd0", rd[31:0], 32'h22);
        check("t4_stall3_rd1", rd[63:32], 32'hDEADBEEF);
        we = 1'b0; wt = 1'b0; raddr = {5'd3, 5'd9};
        step();
        check("t4_release_rd0", rd[31:0], 32'h99);
        check("t4_release_rd1", rd[63:32], 32'h22);

        // T5: out-of-range accesses on the 16-entry configuration.
        raddr = '0;
        step();
        check("t5_idle_ill16", 32'(ill16), 32'd0);
        we = 1'b1; waddr = 5'h11; wdata = 32'hFF;
        step();
        check("t5_wr_ill16", 32'(ill16), 32'd1);
        check("t5_wr_ill32", 32'(ill), 32'd0);
        we = 1'b0; raddr = {5'd0, 5'd1};
        step();
        check("t5_pulse_end", 32'(ill16), 32'd0);
        check("t5_x1_untouched", rd16[31:0], 32'd0);
        raddr = {5'd0, 5'h11};
        step();
        check("t5_rd_x17_16", rd16[31:0], 32'd0);
        check("t5_rd_ill16", 32'(ill16), 32'd1);
        check("t5_rd_x17_32", rd[31:0], 32'hFF);
        wt = 1'b1;
        step();
        check("t5_stall_no_ill", 32'(ill16), 32'd0);
        wt = 1'b0; raddr = '0; we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        step();
        check("t5_x0_wr_no_ill", 32'(ill) | 32'(ill16), 32'd0);
        we = 1'b0;
        step();
        check("t5_x0_reads_zero", rd[31:0], 32'd0);

        // T6: reset while running, then a second reset in the middle of the scrub.
        we = 1'b1; waddr = 5'd9; wdata = 32'hAA;
        step();
        we = 1'b0; raddr = {5'd0, 5'd9};
        step();
        check("t6_x9_written", rd[31:0], 32'hAA);
        rst = 1'b1;
        #1;
        check("t6_async_rdata", rd[31:0], 32'd0);
        check("t6_async_busy", 32'(busy), 32'd1);
        step();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) step();
        check("t6_mid_scrub_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_mid_busy", 32'(busy), 32'd1);
        check("t6_rst_mid_rdata", rd[31:0] | rd[63:32], 32'd0);
        step();
        scrub_count(e32, e16);
        check("t6_scrub_edges32", 32'(e32), 32'd32);
        step();
        check("t6_x9_cleared", rd[31:0], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
